mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Two-master arbiter that shares the single memory bus of `mips_cpu_bus` between the instruction-fetch port (master 0) and the load/store port (master 1). It presents one request/waitrequest bus master interface to memory. Ownership alternates round-robin. It tags fixed-latency read data back to the master that issued the read. It sits between the CPU's internal fetch/data units and the external `address/read/write/waitrequest/readdata` pins.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `clk` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-low (`reset==0` resets)
- `m0_address`, `m1_address` in AW: master byte address
- `m0_read`, `m1_read` in 1: read request, held until accepted
- `m0_write`, `m1_write` in 1: write request, held until accepted
- `m0_writedata`, `m1_writedata` in DW: write data
- `m0_byteenable`, `m1_byteenable` in 4: byte lanes
- `m0_waitrequest`, `m1_waitrequest` out 1: high = command not accepted this cycle
- `m0_readdata`, `m1_readdata` out DW: read data
- `m0_readdatavalid`, `m1_readdatavalid` out 1: readdata valid this cycle
- `address` out AW: slave address
- `read`, `write` out 1: slave command strobes
- `writedata` out DW: slave write data
- `byteenable` out 4: slave byte lanes
- `waitrequest` in 1: slave stall
- `readdata` in DW: slave read data, valid exactly 1 cycle after read acceptance

## Operation
- Master request: `mX_req = mX_read | mX_write`. If a master asserts both, the write wins and the read is masked.
- States (`arb_state_t`):
  - `ARB_IDLE`: no owner.
  - `ARB_BUSY`: `owner` register (0/1) drives the slave.
- `ARB_IDLE`:
  - Slave `read`/`write`=0, `address`/`writedata`/`byteenable`=0, both `mX_waitrequest`=1.
  - If any request is present, pick a winner, load `owner`, and go to `ARB_BUSY`.
- `ARB_BUSY`:
  - Slave outputs mux from `owner`. `m[owner]_waitrequest = waitrequest`. The non-owner's waitrequest is 1.
- Acceptance: occurs in a cycle where the owner has a request and `waitrequest==0`.
  - Set `last_grant=owner`.
  - If a request is pending, re-arbitrate in the same cycle (back-to-back, no idle bubble) and stay in `ARB_BUSY` with the new owner. Otherwise go to `ARB_IDLE`.
- Abandon: if the owner drops its request in `ARB_BUSY`, slave strobes are 0 that cycle, there is no acceptance, and the state goes to `ARB_IDLE`. `last_grant` is unchanged.
- Round-robin pick:
  - Only one master requesting: it wins.
  - Both requesting: the master ≠ `last_grant` wins.
- Read return:
  - On acceptance of a read, register `rd_pend=1` and `rd_id=owner`.
  - Next cycle, assert `m[rd_id]_readdatavalid`. `readdata` is routed to both `mX_readdata` unconditionally; masters qualify it with `readdatavalid`.
- Writes produce no response.

## Timing
- Reset values: state `ARB_IDLE`, `owner`=0, `last_grant`=1 (master 0 wins the first tie), `rd_pend`=0, both `readdatavalid`=0.
  - During reset, slave `read`/`write`=0 and both `mX_waitrequest`=1.
- Grant latency from `ARB_IDLE`: request at edge N, slave strobe visible in cycle N+1, earliest acceptance in N+1.
- Back-to-back: after acceptance in cycle N, the next owner's command is on the slave in N+1.
- Read data: acceptance in cycle N gives `mX_readdatavalid` high for exactly cycle N+1.
  - A new acceptance in N+1 does not disturb the N+1 valid pulse.
- Slave `waitrequest` held high: the owner keeps the bus indefinitely and the other master starves. This is required, with no timeout.
- Reset asserted mid-transaction: everything returns asynchronously to reset values. A pending `readdatavalid` is dropped, and slave strobes fall without waiting for a clock edge.
- All outputs are combinational from state/owner plus master and slave inputs. There are no combinational paths from `waitrequest` to state except through `owner`.

## Structure
- Package `mips_bus_pkg`:
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_BUSY`}
  - `master_id_t` (1 bit), constants `MID_FETCH`=0 and `MID_DATA`=1
  - Bus width constants
- Sub-module `mips_bus_rr_pick`: combinational two-requester round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: `grant_valid`, `grant_id`.
  - Reused later by a DMA/debug master extension.

## Test plan
- Single fetch read:
  - Stimulus: `m0_read`, `m0_address=BFC00000`, memory returns `3C08BFC0`, `waitrequest=0`.
  - Required: `read`=1 at cycle 1, `m0_waitrequest`=0 at cycle 1, `m0_readdatavalid`=1 with `3C08BFC0` at cycle 2, `m1_readdatavalid`=0 throughout.
- Simultaneous requests after reset:
  - Stimulus: m0 reads `BFC00004`, m1 writes `000000FF` to `BFC00030`.
  - Required: m0 is granted first and m1 follows back-to-back in the next cycle. The memory word at index 12 becomes `000000FF`.
- Fairness:
  - Stimulus: both masters requesting continuously for 8 transfers.
  - Required: grants alternate 0,1,0,1,… and each master gets exactly 4.
- Stall:
  - Stimulus: `waitrequest` held high 5 cycles during an m1 write, with m0 also requesting.
  - Required: `m1_waitrequest` mirrors `waitrequest` for those 5 cycles, `m0_waitrequest`=1 throughout, and the slave address/data stay stable. m0 is granted in the cycle after m1 is accepted.
- Abandon:
  - Stimulus: m0 drops `m0_read` while stalled.
  - Required: `read`=0 that cycle, state returns to idle, and no `readdatavalid` is asserted.
- Reset mid-read:
  - Stimulus: `reset` driven to 0 between acceptance and the data cycle.
  - Required: `m0_readdatavalid` never pulses, `read`/`write` fall immediately, both `mX_waitrequest`=1, and after release master 0 wins the first tie.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus memory arbiter.
package mips_bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t MID_FETCH = 1'b0;
  localparam master_id_t MID_DATA  = 1'b1;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Combinational two-requester round-robin picker. A lone requester wins;
// on a tie the requester that was not granted last wins.
module mips_bus_rr_pick
  import mips_bus_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  output logic       grant_valid,
  output master_id_t grant_id
);

  // Winner selection from the request vector and the previous grant.
  always_comb begin
    grant_valid = |req;
    grant_id    = MID_FETCH;
    case (req)
      2'b01:   grant_id = MID_FETCH;
      2'b10:   grant_id = MID_DATA;
      2'b11:   grant_id = master_id_t'(~last_grant);
      default: grant_id = MID_FETCH;
    endcase
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares the single mips_cpu_bus memory port between instruction fetch
// (master 0) and load/store (master 1), round-robin, and steers the
// fixed one-cycle-latency read data back to the master that issued it.
//
// Handshake: a master holds read or write (write wins if both) until a
// cycle in which its waitrequest is low; that cycle is the acceptance.
// The slave side accepts a command in any cycle with waitrequest low, and
// returns readdata exactly one cycle after a read is accepted.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      m0_address,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DW-1:0]      m0_writedata,
  input  logic [BUS_BEW-1:0] m0_byteenable,
  output logic               m0_waitrequest,
  output logic [DW-1:0]      m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [AW-1:0]      m1_address,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DW-1:0]      m1_writedata,
  input  logic [BUS_BEW-1:0] m1_byteenable,
  output logic               m1_waitrequest,
  output logic [DW-1:0]      m1_readdata,
  output logic               m1_readdatavalid,
  output logic [AW-1:0]      address,
  output logic               read,
  output logic               write,
  output logic [DW-1:0]      writedata,
  output logic [BUS_BEW-1:0] byteenable,
  input  logic               waitrequest,
  input  logic [DW-1:0]      readdata,
  output arb_state_t         dbg_state
);

  arb_state_t state;
  master_id_t owner;
  master_id_t last_grant;
  master_id_t rd_id;
  logic       rd_pend;

  logic [1:0] req;
  logic [1:0] rd_req;
  logic       busy;
  logic       owner_req;
  logic       owner_rd;
  logic       owner_wr;
  logic       accept;
  logic [1:0] pick_req;
  master_id_t pick_last;
  logic       grant_valid;
  master_id_t grant_id;

  assign req       = {m1_read | m1_write, m0_read | m0_write};
  assign rd_req    = {m1_read & ~m1_write, m0_read & ~m0_write};
  assign busy      = (state == ARB_BUSY);
  assign owner_req = req[owner];
  assign owner_rd  = rd_req[owner];
  assign owner_wr  = (owner == MID_DATA) ? m1_write : m0_write;
  assign accept    = busy & owner_req & ~waitrequest;

  // While busy, only the other master counts as pending: the owner's
  // request is the command being accepted right now.
  assign pick_req  = busy ? (req & ~(2'b01 << owner)) : req;
  assign pick_last = busy ? owner : last_grant;

  mips_bus_rr_pick u_pick (
    .req         (pick_req),
    .last_grant  (pick_last),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Slave-side mux and per-master waitrequest/readdatavalid steering.
  always_comb begin
    read             = busy & owner_rd;
    write            = busy & owner_wr;
    address          = '0;
    writedata        = '0;
    byteenable       = '0;
    if (busy) begin
      address    = (owner == MID_DATA) ? m1_address    : m0_address;
      writedata  = (owner == MID_DATA) ? m1_writedata  : m0_writedata;
      byteenable = (owner == MID_DATA) ? m1_byteenable : m0_byteenable;
    end
    m0_waitrequest   = ~(busy && owner == MID_FETCH) | waitrequest;
    m1_waitrequest   = ~(busy && owner == MID_DATA)  | waitrequest;
    m0_readdata      = readdata;
    m1_readdata      = readdata;
    m0_readdatavalid = rd_pend & (rd_id == MID_FETCH);
    m1_readdatavalid = rd_pend & (rd_id == MID_DATA);
    dbg_state        = state;
  end

  // Ownership FSM with back-to-back handover and read-return tagging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      owner      <= MID_FETCH;
      last_grant <= MID_DATA;
      rd_pend    <= 1'b0;
      rd_id      <= MID_FETCH;
    end else begin
      rd_pend <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner <= grant_id;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!owner_req) begin
            state <= ARB_IDLE;
          end else if (accept) begin
            last_grant <= owner;
            rd_pend    <= owner_rd;
            rd_id      <= owner;
            if (grant_valid) begin
              owner <= grant_id;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter with a small memory slave model and
// per-master read-data scoreboards.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        slave_wait;
  logic [31:0] readdata_r;
  arb_state_t  dbg_state;

  mips_bus_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .address          (address),
    .read             (read),
    .write            (write),
    .writedata        (writedata),
    .byteenable       (byteenable),
    .waitrequest      (slave_wait),
    .readdata         (readdata_r),
    .dbg_state        (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory slave model ----------------
  logic [31:0] wmem [64];
  bit          written [64];

  function automatic logic [31:0] init_word(input logic [5:0] idx);
    return (idx == 6'd0) ? 32'h3C08BFC0 : (32'hA5000000 | {26'b0, idx});
  endfunction

  function automatic logic [31:0] word_at(input logic [5:0] idx);
    return written[idx] ? wmem[idx] : init_word(idx);
  endfunction

  always @(posedge clk) begin : slave_model
    logic [31:0] nw;
    if (read && !slave_wait) readdata_r <= word_at(address[7:2]);
    if (write && !slave_wait) begin
      nw = word_at(address[7:2]);
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) nw[8*b +: 8] = writedata[8*b +: 8];
      wmem[address[7:2]]    <= nw;
      written[address[7:2]] <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic        grant_log[$];
  bit          log_en = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m0_readdatavalid) begin
      if (exp_q0.size() == 0) check("m0_rdv_unexpected", m0_readdatavalid, 1'b0);
      else check("m0_readdata", m0_readdata, exp_q0.pop_front());
    end
    if (m1_readdatavalid) begin
      if (exp_q1.size() == 0) check("m1_rdv_unexpected", m1_readdatavalid, 1'b0);
      else check("m1_readdata", m1_readdata, exp_q1.pop_front());
    end
    if (log_en && (read || write) && !slave_wait)
      grant_log.push_back(m0_waitrequest ? 1'b1 : 1'b0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int id, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = data; m0_byteenable = 4'hF;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = data; m1_byteenable = 4'hF;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    slave_wait = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One command from a master: hold it until accepted, then release.
  task automatic master_cmd(input int id, input bit wr, input int idx,
                            input logic [31:0] data, output int acc);
    logic [31:0] addr;
    logic        mw;
    addr = 32'hBFC00000 + 32'(idx * 4);
    set_m(id, !wr, wr, addr, data);
    if (!wr) begin
      if (id == 0) exp_q0.push_back(word_at(6'(idx)));
      else         exp_q1.push_back(word_at(6'(idx)));
    end
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      mw = (id == 0) ? m0_waitrequest : m1_waitrequest;
      if (mw == 1'b0) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("grant_timeout", mw, 1'b0);
    tick();
    set_m(id, 1'b0, 1'b0, addr, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a0, a1, d0, d1, n0, wait_n;

    // Reset state
    reset = 1'b0;
    slave_wait = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("rst_read", read, 1'b0);
    check("rst_write", write, 1'b0);
    check("rst_m0_wait", m0_waitrequest, 1'b1);
    check("rst_m1_wait", m1_waitrequest, 1'b1);
    check("rst_m0_rdv", m0_readdatavalid, 1'b0);
    check("rst_m1_rdv", m1_readdatavalid, 1'b0);
    check("rst_state", dbg_state, ARB_IDLE);
    tick();
    reset = 1'b1;

    // Single fetch read
    set_m(0, 1'b1, 1'b0, 32'hBFC00000, 32'h0);
    exp_q0.push_back(32'h3C08BFC0);
    @(negedge clk);
    check("t1_c0_read", read, 1'b0);
    check("t1_c0_m0_wait", m0_waitrequest, 1'b1);
    @(negedge clk);
    check("t1_c1_read", read, 1'b1);
    check("t1_c1_addr", address, 32'hBFC00000);
    check("t1_c1_m0_wait", m0_waitrequest, 1'b0);
    check("t1_c1_m1_wait", m1_waitrequest, 1'b1);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t1_c2_m0_rdv", m0_readdatavalid, 1'b1);
    check("t1_c2_m1_rdv", m1_readdatavalid, 1'b0);
    check("t1_c2_read", read, 1'b0);

    // Simultaneous requests after reset
    do_reset();
    fork
      master_cmd(0, 1'b0, 1, 32'h0, a0);
      master_cmd(1, 1'b1, 12, 32'h000000FF, a1);
    join
    check("t2_m1_back_to_back", a1, a0 + 1);
    check("t2_mem12", word_at(6'd12), 32'h000000FF);

    // Fairness: both masters requesting continuously
    log_en = 1;
    fork
      begin
        for (int k = 0; k < 4; k++) master_cmd(0, 1'b0, 2 + k, 32'h0, d0);
      end
      begin
        for (int k = 0; k < 4; k++) master_cmd(1, 1'b1, 20 + k, 32'hC0DE0000 + 32'(k), d1);
      end
    join
    log_en = 0;
    check("t3_grant_count", grant_log.size(), 8);
    n0 = 0;
    for (int i = 0; i < grant_log.size(); i++) begin
      check("t3_grant_order", grant_log[i], i % 2);
      if (grant_log[i] == 1'b0) n0++;
    end
    check("t3_m0_grants", n0, 4);
    for (int k = 0; k < 4; k++)
      check("t3_mem_write", word_at(6'(20 + k)), 32'hC0DE0000 + 32'(k));

    // Stall: m1 owns the bus while the slave holds waitrequest high
    slave_wait = 1'b1;
    set_m(1, 1'b0, 1'b1, 32'hBFC00060, 32'h12345678);
    tick();
    set_m(0, 1'b1, 1'b0, 32'hBFC00018, 32'h0);
    exp_q0.push_back(word_at(6'd6));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_m1_wait_mirror", m1_waitrequest, slave_wait);
      check("t4_m0_wait", m0_waitrequest, 1'b1);
      check("t4_write", write, 1'b1);
      check("t4_addr", address, 32'hBFC00060);
      check("t4_wdata", writedata, 32'h12345678);
      if (i < 4) tick();
    end
    tick();
    slave_wait = 1'b0;
    @(negedge clk);
    check("t4_m1_accept", m1_waitrequest, 1'b0);
    check("t4_m0_still_wait", m0_waitrequest, 1'b1);
    tick();
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t4_m0_granted_read", read, 1'b1);
    check("t4_m0_granted_addr", address, 32'hBFC00018);
    check("t4_m0_granted_wait", m0_waitrequest, 1'b0);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t4_mem24", word_at(6'd24), 32'h12345678);

    // Abandon: m0 drops its read while stalled
    slave_wait = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'hBFC0001C, 32'h0);
    tick();
    @(negedge clk);
    check("t5_read_up", read, 1'b1);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t5_read_dropped", read, 1'b0);
    check("t5_rdv_a", m0_readdatavalid, 1'b0);
    tick();
    slave_wait = 1'b0;
    @(negedge clk);
    check("t5_state_idle", dbg_state, ARB_IDLE);
    check("t5_rdv_b", m0_readdatavalid, 1'b0);

    // Reset asserted between acceptance and the data cycle
    tick();
    set_m(0, 1'b1, 1'b0, 32'hBFC00020, 32'h0);
    tick();
    @(negedge clk);
    check("t6_read_up", read, 1'b1);
    check("t6_accepting", m0_waitrequest, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_read_async", read, 1'b0);
    check("t6_write_async", write, 1'b0);
    check("t6_m0_wait", m0_waitrequest, 1'b1);
    check("t6_m1_wait", m1_waitrequest, 1'b1);
    check("t6_state", dbg_state, ARB_IDLE);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    check("t6_no_rdv", m0_readdatavalid, 1'b0);
    tick();
    reset = 1'b1;
    fork
      master_cmd(0, 1'b0, 9, 32'h0, a0);
      master_cmd(1, 1'b0, 10, 32'h0, a1);
    join
    check("t6_m0_first_tie", a0 < a1, 1'b1);

    // Drain outstanding read returns
    wait_n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && wait_n < 10) begin
      tick();
      wait_n++;
    end
    check("q0_left", exp_q0.size(), 0);
    check("q1_left", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
